// File: rtl/fir_out_stage.sv
// -----------------------------------------------------------------------------
// fir_out_stage
//
// Output stage that sits after the FIR accumulator in the clk_1mhz domain.
// Each accumulator result is rounded (round-half-up), arithmetically shifted
// down by SHIFT, saturated to OUT_W bits and queued in a small
// first-word-fall-through FIFO that drives a ready/valid consumer.
//
// Pipeline:
//   edge k   : y_in captured and rounded            (stage 1)
//   edge k+1 : shifted and saturated                (stage 2)
//   edge k+2 : written into the FIFO, out_valid set (stage 3)
// The FIR is never stalled. A result that arrives at a full FIFO, with no pop
// in the same cycle, is dropped and recorded in drop_sticky.
//
// Parameters:
//   IN_W   width of the signed accumulator input
//   OUT_W  width of the signed output sample
//   SHIFT  right shift after rounding (0 = no rounding, no shift)
//   DEPTH  FIFO entries, power of two, >= 2
//
// Ports:
//   clk_1mhz     clock, rising edge
//   rst_n        asynchronous active-low reset
//   y_in         signed accumulator result
//   y_valid      one-cycle strobe qualifying y_in
//   out_data     signed sample at the FIFO head (holds last value when empty)
//   out_sat      head sample was clipped
//   out_valid    FIFO not empty
//   out_ready    consumer accepts the head sample
//   level        FIFO occupancy, 0..DEPTH
//   drop_sticky  a sample was lost because the FIFO was full
//   clr_drop     synchronous clear for drop_sticky (and the counters)
//
// Optional feature, macro FIR_OUT_STATS_EN:
//   sat_count    saturating count of pushed entries with sat=1
//   drop_count   saturating count of dropped samples
// -----------------------------------------------------------------------------
module fir_out_stage #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 8
) (
  input  logic                     clk_1mhz,
  input  logic                     rst_n,
  input  logic [IN_W-1:0]          y_in,
  input  logic                     y_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_sticky,
  input  logic                     clr_drop
`ifdef FIR_OUT_STATS_EN
  ,
  output logic [15:0]              sat_count,
  output logic [15:0]              drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  // Saturation bounds expressed at the (IN_W+1)-bit width of the shifted value.
  localparam logic signed [IN_W:0] MAX_S =
    $signed({{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [IN_W:0] MIN_S =
    $signed({{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});

  localparam logic [OUT_W-1:0] POS_CLIP = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_CLIP = {1'b1, {(OUT_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Stage 1: round. One extra bit so adding the half-LSB never wraps.
  // ---------------------------------------------------------------------------
  logic [IN_W:0]          rnd_sum;
  logic signed [IN_W:0]   s1_r_reg;
  logic                   s1_valid_reg;

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
      assign rnd_sum = {y_in[IN_W-1], y_in} + HALF;
    end else begin : g_no_round
      assign rnd_sum = {y_in[IN_W-1], y_in};
    end
  endgenerate

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_r_reg     <= '0;
    end else begin
      s1_valid_reg <= y_valid;
      if (y_valid) begin
        s1_r_reg <= $signed(rnd_sum);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: arithmetic shift and saturate.
  // ---------------------------------------------------------------------------
  logic signed [IN_W:0]   shifted;
  logic [OUT_W-1:0]       sat_data;
  logic                   sat_flag;
  logic [OUT_W-1:0]       s2_data_reg;
  logic                   s2_sat_reg;
  logic                   s2_valid_reg;

  assign shifted = s1_r_reg >>> SHIFT;

  always_comb begin
    sat_data = shifted[OUT_W-1:0];
    sat_flag = 1'b0;
    if (shifted > MAX_S) begin
      sat_data = POS_CLIP;
      sat_flag = 1'b1;
    end else if (shifted < MIN_S) begin
      sat_data = NEG_CLIP;
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_sat_reg   <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_data_reg <= sat_data;
        s2_sat_reg  <= sat_flag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: FWFT FIFO of {sat, data} entries.
  // ---------------------------------------------------------------------------
  logic [OUT_W:0]         mem [DEPTH];
  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [LW-1:0]          count_reg;
  logic [OUT_W:0]         hold_reg;
  logic [OUT_W:0]         head;
  logic                   fifo_full;
  logic                   pop;
  logic                   push_ok;
  logic                   drop;

  assign fifo_full = (count_reg == LVL_FULL);
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = s2_valid_reg && (!fifo_full || pop);
  assign drop      = s2_valid_reg && !push_ok;
  assign level     = count_reg;

  // While empty, the outputs replay the last presented head so they never
  // go unknown and never show stale RAM contents.
  assign head     = out_valid ? mem[rd_ptr_reg] : hold_reg;
  assign out_data = head[OUT_W-1:0];
  assign out_sat  = head[OUT_W];

  // Storage carries no reset: it is only observed through count_reg, which is.
  always_ff @(posedge clk_1mhz) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= {s2_sat_reg, s2_data_reg};
    end
  end

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      hold_reg   <= '0;
    end else begin
      hold_reg <= head;
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + LVL_ONE;
        2'b01:   count_reg <= count_reg - LVL_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A drop in the same cycle as clr_drop leaves the flag set.
  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      drop_sticky <= 1'b0;
    end else if (drop) begin
      drop_sticky <= 1'b1;
    end else if (clr_drop) begin
      drop_sticky <= 1'b0;
    end
  end

`ifdef FIR_OUT_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters: saturate at all-ones, clr_drop beats an increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      sat_count  <= '0;
      drop_count <= '0;
    end else if (clr_drop) begin
      sat_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push_ok && s2_sat_reg && (sat_count != 16'hFFFF)) begin
        sat_count <= sat_count + 16'd1;
      end
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule
